// File: rtl/lcd_pkg.sv
// lcd_pkg: command codes, sequencer states and image geometry shared by the LCD blocks
package lcd_pkg;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int IMG_PIX = IMG_W * IMG_H;
  localparam logic [3:0] CMD_WRITE = 4'h0;
  localparam logic [3:0] CMD_SHIFT_UP = 4'h1;
  localparam logic [3:0] CMD_SHIFT_DOWN = 4'h2;
  localparam logic [3:0] CMD_SHIFT_LEFT = 4'h3;
  localparam logic [3:0] CMD_SHIFT_RIGHT = 4'h4;
  localparam logic [3:0] CMD_MAX = 4'h5;
  localparam logic [3:0] CMD_MIN = 4'h6;
  localparam logic [3:0] CMD_AVERAGE = 4'h7;
  localparam logic [3:0] CMD_CCW = 4'h8;
  localparam logic [3:0] CMD_CW = 4'h9;
  localparam logic [3:0] CMD_MIRROR_X = 4'hA;
  localparam logic [3:0] CMD_MIRROR_Y = 4'hB;
  localparam logic [3:0] CMD_LAST_LEGAL = 4'hB;
  typedef enum logic [2:0] {ST_LOAD, ST_IDLE, ST_ISSUE, ST_GAP, ST_FIN, ST_DONE} seq_state_t;
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: command FIFO with occupancy counter and synchronous flush
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [3:0]               din,
  output logic [3:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign level = cnt;
  assign dout = mem[rptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= do_push ? wptr + 1'b1 : wptr;
      rptr <= do_pop ? rptr + 1'b1 : rptr;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wptr] <= din;
endmodule

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: buffers host commands and issues them to the LCD controller when it is not busy
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [3:0]             cmd,
  output logic                   cmd_valid,
  input  logic                   busy,
  input  logic                   done,
  output logic                   seq_done,
  output logic [7:0]             issued_cnt,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int GW = $clog2(GAP + 1);
  seq_state_t state, state_nx;
  logic [GW-1:0] gap_cnt;
  logic [3:0] head;
  logic full, empty, pop, accept, legal;
  assign legal = host_cmd <= CMD_LAST_LEGAL;
  assign host_ready = !full && state != ST_FIN && state != ST_DONE;
  assign accept = host_valid && host_ready;
  assign seq_done = state == ST_DONE;
  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(state == ST_FIN),
    .push(accept && legal),
    .pop(pop),
    .din(host_cmd),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // LOAD issues directly once busy drops so the first strobe follows busy by one cycle
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      ST_LOAD, ST_IDLE: if (!busy) begin
        pop = !empty;
        state_nx = empty ? ST_IDLE : ST_ISSUE;
      end
      ST_ISSUE: state_nx = cmd == CMD_WRITE ? ST_FIN : ST_GAP;
      ST_GAP: state_nx = gap_cnt == '0 ? ST_IDLE : ST_GAP;
      ST_FIN: state_nx = done ? ST_DONE : ST_FIN;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_LOAD;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cmd <= '0;
      cmd_valid <= 1'b0;
      issued_cnt <= '0;
      drop_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      cmd_valid <= pop;
      cmd <= pop ? head : cmd;
      issued_cnt <= pop && issued_cnt != 8'hFF ? issued_cnt + 8'd1 : issued_cnt;
      drop_cnt <= accept && !legal && drop_cnt != 8'hFF ? drop_cnt + 8'd1 : drop_cnt;
      gap_cnt <= state == ST_ISSUE ? GW'(GAP - 1) : state == ST_GAP && gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt;
    end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: directed scenarios for the command sequencer with hand-computed expectations
module tb_lcd_cmd_seq;
  import lcd_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] host_cmd = '0;
  logic host_valid = 1'b0;
  logic host_ready;
  logic [3:0] cmd;
  logic cmd_valid;
  logic busy = 1'b1;
  logic done = 1'b0;
  logic seq_done;
  logic [7:0] issued_cnt, drop_cnt;
  logic [3:0] fifo_level;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  logic prev_v = 1'b0;
  logic [3:0] q_cmd [$];
  int q_cyc [$];

  lcd_cmd_seq #(.DEPTH(8), .GAP(1)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .seq_done(seq_done), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (cmd_valid) begin
      q_cmd.push_back(cmd);
      q_cyc.push_back(cyc);
    end
    if (cmd_valid && prev_v) begin
      failures++;
      $display("FAIL strobe_twice cmd_valid high in consecutive cycles at cycle %0d", cyc);
    end
    prev_v = cmd_valid;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic b);
    @(negedge clk);
    busy = b;
    host_valid = 1'b0;
    done = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = q_cmd.size();
  endtask

  task automatic push(input logic [3:0] c);
    host_cmd = c;
    host_valid = 1'b1;
    tick;
    host_valid = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(1'b1);
    checks++;
    if ({cmd, cmd_valid, seq_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs cmd=%h cmd_valid=%b seq_done=%b expected 0 0 0", cmd, cmd_valid, seq_done);
    end
    checks++;
    if (issued_cnt !== 8'd0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts issued=%0d drop=%0d expected 0 0", issued_cnt, drop_cnt);
    end
    checks++;
    if (fifo_level !== 4'd0 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fifo level=%0d host_ready=%b expected 0 1", fifo_level, host_ready);
    end
  endtask

  task automatic test_load;
    logic [3:0] exp [3] = '{4'h5, 4'h1, 4'h0};
    apply_reset(1'b1);
    push(4'h5);
    push(4'h1);
    push(4'h0);
    done = 1'b1;
    tick;
    done = 1'b0;
    repeat (IMG_PIX - 4) tick;
    checks++;
    if (q_cmd.size() != base || fifo_level !== 4'd3) begin
      failures++;
      $display("FAIL load_holdoff strobes=%0d level=%0d expected 0 3", q_cmd.size() - base, fifo_level);
    end
    busy = 1'b0;
    tick;
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 4'h5) begin
      failures++;
      $display("FAIL load_first cmd_valid=%b cmd=%h expected 1 5", cmd_valid, cmd);
    end
    repeat (10) tick;
    checks++;
    if (q_cmd.size() != base + 3) begin
      failures++;
      $display("FAIL load_count strobes=%0d expected 3", q_cmd.size() - base);
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_cmd[base+i] !== exp[i]) begin
          failures++;
          $display("FAIL load_order idx=%0d cmd=%h expected %h", i, q_cmd[base+i], exp[i]);
        end
      end
    checks++;
    if (issued_cnt !== 8'd3 || seq_done !== 1'b0) begin
      failures++;
      $display("FAIL load_end issued=%0d seq_done=%b expected 3 0", issued_cnt, seq_done);
    end
  endtask

  task automatic test_ordered;
    logic [3:0] exp [4] = '{4'h3, 4'h3, 4'h9, 4'h0};
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) push(exp[i]);
    busy = 1'b0;
    repeat (16) tick;
    checks++;
    if (q_cmd.size() != base + 4) begin
      failures++;
      $display("FAIL ordered_count strobes=%0d expected 4", q_cmd.size() - base);
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_cmd[base+i] !== exp[i]) begin
          failures++;
          $display("FAIL ordered_cmd idx=%0d cmd=%h expected %h", i, q_cmd[base+i], exp[i]);
        end
        if (i > 0) begin
          checks++;
          if (q_cyc[base+i] - q_cyc[base+i-1] != 3) begin
            failures++;
            $display("FAIL ordered_spacing idx=%0d gap=%0d expected 3", i, q_cyc[base+i] - q_cyc[base+i-1]);
          end
        end
      end
    checks++;
    if (issued_cnt !== 8'd4 || seq_done !== 1'b0 || host_ready !== 1'b0) begin
      failures++;
      $display("FAIL ordered_fin issued=%0d seq_done=%b host_ready=%b expected 4 0 0", issued_cnt, seq_done, host_ready);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (seq_done !== 1'b1) begin
      failures++;
      $display("FAIL ordered_done seq_done=%b expected 1", seq_done);
    end
    repeat (3) tick;
    checks++;
    if (seq_done !== 1'b1 || host_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_sticky seq_done=%b host_ready=%b expected 1 0", seq_done, host_ready);
    end
  endtask

  task automatic test_full;
    apply_reset(1'b1);
    for (int i = 1; i <= 8; i++) push(4'(i));
    host_cmd = 4'h9;
    host_valid = 1'b1;
    #1;
    checks++;
    if (host_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready host_ready=%b expected 0", host_ready);
    end
    tick;
    host_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd8) begin
      failures++;
      $display("FAIL full_level level=%0d expected 8", fifo_level);
    end
    busy = 1'b0;
    repeat (30) tick;
    checks++;
    if (q_cmd.size() != base + 8) begin
      failures++;
      $display("FAIL full_count strobes=%0d expected 8", q_cmd.size() - base);
    end else
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_cmd[base+i] !== 4'(i + 1)) begin
          failures++;
          $display("FAIL full_order idx=%0d cmd=%h expected %h", i, q_cmd[base+i], 4'(i + 1));
        end
      end
  endtask

  task automatic test_illegal;
    apply_reset(1'b1);
    push(4'hC);
    push(4'hF);
    push(4'h7);
    checks++;
    if (drop_cnt !== 8'd2 || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL illegal_drop drop=%0d level=%0d expected 2 1", drop_cnt, fifo_level);
    end
    busy = 1'b0;
    repeat (8) tick;
    checks++;
    if (q_cmd.size() != base + 1 || q_cmd[q_cmd.size()-1] !== 4'h7) begin
      failures++;
      $display("FAIL illegal_issue strobes=%0d last=%h expected 1 7", q_cmd.size() - base, q_cmd[q_cmd.size()-1]);
    end
  endtask

  task automatic test_busy_stall;
    apply_reset(1'b0);
    repeat (3) tick;
    busy = 1'b1;
    push(4'h4);
    push(4'h6);
    repeat (8) tick;
    checks++;
    if (q_cmd.size() != base) begin
      failures++;
      $display("FAIL stall_hold strobes=%0d expected 0", q_cmd.size() - base);
    end
    busy = 1'b0;
    tick;
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 4'h4) begin
      failures++;
      $display("FAIL stall_first cmd_valid=%b cmd=%h expected 1 4", cmd_valid, cmd);
    end
    repeat (6) tick;
    checks++;
    if (q_cmd.size() != base + 2 || q_cmd[q_cmd.size()-1] !== 4'h6) begin
      failures++;
      $display("FAIL stall_second strobes=%0d last=%h expected 2 6", q_cmd.size() - base, q_cmd[q_cmd.size()-1]);
    end
  endtask

  task automatic test_midreset;
    apply_reset(1'b1);
    for (int i = 1; i <= 5; i++) push(4'(i));
    busy = 1'b0;
    tick;
    tick;
    checks++;
    if (fifo_level !== 4'd4 || cmd !== 4'h1) begin
      failures++;
      $display("FAIL mid_pre level=%0d cmd=%h expected 4 1", fifo_level, cmd);
    end
    busy = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (fifo_level !== 4'd0 || cmd !== 4'h0 || cmd_valid !== 1'b0 || issued_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset level=%0d cmd=%h valid=%b issued=%0d expected 0 0 0 0", fifo_level, cmd, cmd_valid, issued_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    base = q_cmd.size();
    repeat (4) tick;
    busy = 1'b0;
    repeat (10) tick;
    checks++;
    if (q_cmd.size() != base || fifo_level !== 4'd0 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_stale strobes=%0d level=%0d host_ready=%b expected 0 0 1", q_cmd.size() - base, fifo_level, host_ready);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_ordered;
    test_full;
    test_illegal;
    test_busy_stall;
    test_midreset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
